// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM encoding,
// address-map constants and requester index constants.
package mem_port_arbiter_pkg;

   typedef enum logic [0:0] {
      ARB   = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam logic [3:0]  PERI_BASE_NIBBLE = 4'h4;
   localparam logic [31:0] RAM_LIMIT        = 32'h0000_07FF;

   localparam int OWN_CPU = 0;
   localparam int OWN_DMA = 1;

   // Peripheral space is selected by the top address nibble alone.
   function automatic logic is_peri(input logic [31:0] addr);
      return (addr[31:28] == PERI_BASE_NIBBLE);
   endfunction

   function automatic logic is_ram(input logic [31:0] addr);
      return (addr <= RAM_LIMIT);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_ctr.sv
// Arbiter counters: saturating DMA starvation counter and locked-burst beat
// counter, each exposing only the compare result the FSM needs.
module arb_starve_ctr
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_WAIT  = 8,
   parameter int BURST_MAX = 4,
   parameter int WAIT_BITS = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic dma_req,
   input  logic dma_gnt,
   input  logic burst_load,
   input  logic burst_inc,
   input  logic burst_clr,
   output logic wait_full,
   output logic burst_last
);

   localparam int BURST_BITS = $clog2(BURST_MAX + 1);
   localparam logic [WAIT_BITS-1:0]  WAIT_LIM  = WAIT_BITS'(MAX_WAIT);
   localparam logic [BURST_BITS-1:0] BURST_LIM = BURST_BITS'(BURST_MAX);

   logic [WAIT_BITS-1:0]  wait_cnt_q, wait_cnt_d;
   logic [BURST_BITS-1:0] burst_cnt_q, burst_cnt_d;

   // Starvation count grows while DMA is held off; clears once DMA gets through or stops asking.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!dma_req || dma_gnt) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != WAIT_LIM) begin
         wait_cnt_d = wait_cnt_q + WAIT_BITS'(1);
      end
   end

   // Burst beat count: first beat loads 1, leaving the burst clears it.
   always_comb begin
      burst_cnt_d = burst_cnt_q;
      if (burst_load) begin
         burst_cnt_d = BURST_BITS'(1);
      end else if (burst_clr) begin
         burst_cnt_d = '0;
      end else if (burst_inc) begin
         burst_cnt_d = burst_cnt_q + BURST_BITS'(1);
      end
   end

   // Counter registers, cleared asynchronously so a mid-operation reset restarts cleanly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt_q  <= '0;
         burst_cnt_q <= '0;
      end else begin
         wait_cnt_q  <= wait_cnt_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign wait_full  = (wait_cnt_q == WAIT_LIM);
   // True when the next DMA beat completes the burst.
   assign burst_last = ((burst_cnt_q + BURST_BITS'(1)) == BURST_LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared data-memory/peripheral port: CPU has fixed
// priority, a starved DMA gets one forced beat, and a locked DMA burst holds
// the port for up to BURST_MAX beats. Read data is routed to its issuer.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_WAIT  = 8,
   parameter int BURST_MAX = 4,
   parameter int WAIT_BITS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_stall,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   input  logic        dma_req,
   input  logic        dma_lock,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_gnt,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mem_peri,
   input  logic [31:0] mem_rdata
);

   arb_state_e  state_q, state_d;
   logic [1:0]  rd_owner_q, rd_owner_d;
   logic        cpu_gnt_c, dma_gnt_c;
   logic        burst_load, burst_inc, burst_clr;
   logic        wait_full, burst_last;

   arb_starve_ctr #(
      .MAX_WAIT  (MAX_WAIT),
      .BURST_MAX (BURST_MAX),
      .WAIT_BITS (WAIT_BITS)
   ) u_ctr (
      .clk        (clk),
      .reset      (reset),
      .dma_req    (dma_req),
      .dma_gnt    (dma_gnt_c),
      .burst_load (burst_load),
      .burst_inc  (burst_inc),
      .burst_clr  (burst_clr),
      .wait_full  (wait_full),
      .burst_last (burst_last)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ARB;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: enter BURST on a locked DMA grant, leave when the lock drops or the last beat goes.
   always_comb begin
      state_d    = state_q;
      burst_load = 1'b0;
      burst_inc  = 1'b0;
      burst_clr  = 1'b0;
      case (state_q)
         ARB: begin
            if (dma_gnt_c && dma_lock && (BURST_MAX > 1)) begin
               state_d    = BURST;
               burst_load = 1'b1;
            end
         end
         BURST: begin
            burst_inc = dma_gnt_c;
            if (!dma_lock || (dma_gnt_c && burst_last)) begin
               state_d   = ARB;
               burst_clr = 1'b1;
            end
         end
         default: state_d = ARB;
      endcase
   end

   // Grant outputs: DMA owns the port in BURST; in ARB the CPU wins unless DMA is starved.
   always_comb begin
      cpu_gnt_c = 1'b0;
      dma_gnt_c = 1'b0;
      if (!reset) begin
         if (state_q == BURST) begin
            if (dma_req)      dma_gnt_c = 1'b1;
            else if (cpu_req) cpu_gnt_c = 1'b1;
         end else begin
            if (dma_req && (!cpu_req || wait_full)) dma_gnt_c = 1'b1;
            else if (cpu_req)                       cpu_gnt_c = 1'b1;
         end
      end
   end

   // Memory-side mux from whichever port holds the grant; idle port drives zeros.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      if (cpu_gnt_c) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_read  = !cpu_we;
         mem_write = cpu_we;
      end else if (dma_gnt_c) begin
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
         mem_read  = !dma_we;
         mem_write = dma_we;
      end
   end

   // Remember who issued this cycle's read so next cycle's data goes back to them.
   always_comb begin
      rd_owner_d          = '0;
      rd_owner_d[OWN_CPU] = cpu_gnt_c && !cpu_we;
      rd_owner_d[OWN_DMA] = dma_gnt_c && !dma_we;
   end

   // Read-owner register; async clear drops any read in flight at reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_owner_q <= '0;
      end else begin
         rd_owner_q <= rd_owner_d;
      end
   end

   assign mem_peri   = is_peri(mem_addr);
   assign cpu_gnt    = cpu_gnt_c;
   assign dma_gnt    = dma_gnt_c;
   assign cpu_stall  = cpu_req && !cpu_gnt_c;
   assign cpu_rvalid = rd_owner_q[OWN_CPU];
   assign dma_rvalid = rd_owner_q[OWN_DMA];
   assign cpu_rdata  = mem_rdata;
   assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter with a per-cycle scoreboard.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic        cpu_gnt, cpu_stall, cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        dma_req = 1'b0, dma_lock = 1'b0, dma_we = 1'b0;
   logic [31:0] dma_addr = '0, dma_wdata = '0;
   logic        dma_gnt, dma_rvalid;
   logic [31:0] dma_rdata;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_read, mem_write, mem_peri;
   logic [31:0] mem_rdata = '0;

   int n_cmp  = 0;
   int n_fail = 0;
   int step_id = 0;

   typedef struct {
      int          id;
      logic        creq;
      logic        cg, dg, rd, wr, peri;
      logic [31:0] addr, wd;
      logic        crv, drv;
      logic [31:0] rdata;
   } exp_t;

   exp_t exp_q[$];

   mem_port_arbiter #(.MAX_WAIT(8), .BURST_MAX(4), .WAIT_BITS(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_stall  (cpu_stall),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .dma_req    (dma_req),
      .dma_lock   (dma_lock),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_gnt    (dma_gnt),
      .dma_rvalid (dma_rvalid),
      .dma_rdata  (dma_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_peri   (mem_peri),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL step %0d %s: got %h, expected %h", id, nm, act, req);
      end
   endtask

   // One cycle of stimulus plus the hand-computed response for that cycle.
   task automatic step(input logic rst_i,
                       input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                       input logic dreq, input logic dlock, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd,
                       input logic [31:0] mrd,
                       input logic ecg, input logic edg, input logic erd, input logic ewr, input logic eperi,
                       input logic [31:0] eaddr, input logic [31:0] ewd,
                       input logic ecrv, input logic edrv, input logic [31:0] erdata);
      exp_t e;
      @(posedge clk);
      #1;
      reset     = rst_i;
      cpu_req   = creq;  cpu_we  = cwe;  cpu_addr = caddr; cpu_wdata = cwd;
      dma_req   = dreq;  dma_lock = dlock; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
      mem_rdata = mrd;
      step_id++;
      e.id = step_id; e.creq = creq;
      e.cg = ecg; e.dg = edg; e.rd = erd; e.wr = ewr; e.peri = eperi;
      e.addr = eaddr; e.wd = ewd; e.crv = ecrv; e.drv = edrv; e.rdata = erdata;
      exp_q.push_back(e);
   endtask

   // Monitor: mid-cycle, pop the expected response and compare against the DUT.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk(e.id, "cpu_gnt",    {31'd0, cpu_gnt},    {31'd0, e.cg});
         chk(e.id, "dma_gnt",    {31'd0, dma_gnt},    {31'd0, e.dg});
         chk(e.id, "cpu_stall",  {31'd0, cpu_stall},  {31'd0, e.creq && !e.cg});
         chk(e.id, "mem_read",   {31'd0, mem_read},   {31'd0, e.rd});
         chk(e.id, "mem_write",  {31'd0, mem_write},  {31'd0, e.wr});
         chk(e.id, "mem_peri",   {31'd0, mem_peri},   {31'd0, e.peri});
         chk(e.id, "mem_addr",   mem_addr,  e.addr);
         chk(e.id, "mem_wdata",  mem_wdata, e.wd);
         chk(e.id, "cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, e.crv});
         chk(e.id, "dma_rvalid", {31'd0, dma_rvalid}, {31'd0, e.drv});
         if (e.crv) chk(e.id, "cpu_rdata", cpu_rdata, e.rdata);
         if (e.drv) chk(e.id, "dma_rdata", dma_rdata, e.rdata);
      end
   end

   initial begin
      logic        dcyc, pdma, pcpu;
      logic [31:0] mrd;

      // Reset state, including grants held low while requests are present.
      step(1, 0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0, 32'h0, 0,0,0,0,0,32'h0,32'h0, 0,0,32'h0);
      step(1, 1,0,32'h10,32'h0, 1,0,0,32'h20,32'h0, 32'h0, 0,0,0,0,0,32'h0,32'h0, 0,0,32'h0);
      step(0, 0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0, 32'h0, 0,0,0,0,0,32'h0,32'h0, 0,0,32'h0);

      // CPU-only read at 0x10, data one cycle later to CPU only.
      step(0, 1,0,32'h10,32'h0, 0,0,0,32'h0,32'h0, 32'h0, 1,0,1,0,0,32'h10,32'h0, 0,0,32'h0);
      step(0, 0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0, 32'hDEADBEEF, 0,0,0,0,0,32'h0,32'h0, 1,0,32'hDEADBEEF);
      step(0, 0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0, 32'h0, 0,0,0,0,0,32'h0,32'h0, 0,0,32'h0);

      // DMA peripheral write, no read return afterwards.
      step(0, 0,0,32'h0,32'h0, 1,0,1,32'h4000_0024,32'h41, 32'h0, 0,1,0,1,1,32'h4000_0024,32'h41, 0,0,32'h0);
      step(0, 0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0, 32'h0, 0,0,0,0,0,32'h0,32'h0, 0,0,32'h0);

      // Alternating owners: CPU reads, then DMA reads, each datum routed to its issuer.
      step(0, 1,0,32'h20,32'h0, 0,0,0,32'h0,32'h0, 32'h0, 1,0,1,0,0,32'h20,32'h0, 0,0,32'h0);
      step(0, 0,0,32'h0,32'h0, 1,0,0,32'h30,32'h0, 32'h1111, 0,1,1,0,0,32'h30,32'h0, 1,0,32'h1111);
      step(0, 0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0, 32'h2222, 0,0,0,0,0,32'h0,32'h0, 0,1,32'h2222);

      // Continuous contention without lock: 8 CPU grants then one forced DMA beat, twice.
      for (int i = 1; i <= 18; i++) begin
         dcyc = (i % 9 == 0);
         pdma = (i > 1) && ((i - 1) % 9 == 0);
         pcpu = (i > 1) && !pdma;
         mrd  = 32'hC000_0000 + i;
         step(0, 1,0,32'h100,32'h0, 1,0,0,32'h200,32'h0, mrd,
              !dcyc, dcyc, 1,0,0, dcyc ? 32'h200 : 32'h100, 32'h0, pcpu, pdma, mrd);
      end
      step(0, 0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0, 32'hC000_00FF, 0,0,0,0,0,32'h0,32'h0, 0,1,32'hC000_00FF);

      // Locked burst: 4 DMA beats, then CPU wins with dma_lock still high.
      step(0, 0,0,32'h0,32'h0, 1,1,0,32'h300,32'h0, 32'h0, 0,1,1,0,0,32'h300,32'h0, 0,0,32'h0);
      step(0, 1,0,32'h100,32'h0, 1,1,0,32'h304,32'h0, 32'hA1, 0,1,1,0,0,32'h304,32'h0, 0,1,32'hA1);
      step(0, 1,0,32'h100,32'h0, 1,1,0,32'h308,32'h0, 32'hA2, 0,1,1,0,0,32'h308,32'h0, 0,1,32'hA2);
      step(0, 1,0,32'h100,32'h0, 1,1,0,32'h30C,32'h0, 32'hA3, 0,1,1,0,0,32'h30C,32'h0, 0,1,32'hA3);
      step(0, 1,0,32'h100,32'h0, 1,1,0,32'h310,32'h0, 32'hA4, 1,0,1,0,0,32'h100,32'h0, 0,1,32'hA4);
      step(0, 0,0,32'h0,32'h0, 1,1,0,32'h310,32'h0, 32'hA5, 0,1,1,0,0,32'h310,32'h0, 1,0,32'hA5);
      step(0, 0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0, 32'hA6, 0,0,0,0,0,32'h0,32'h0, 0,1,32'hA6);

      // Reset mid-burst, the cycle after a CPU read grant: the read is dropped.
      step(0, 0,0,32'h0,32'h0, 1,1,1,32'h4000_0000,32'h5, 32'h0, 0,1,0,1,1,32'h4000_0000,32'h5, 0,0,32'h0);
      step(0, 1,0,32'h44,32'h0, 0,1,0,32'h0,32'h0, 32'h0, 1,0,1,0,0,32'h44,32'h0, 0,0,32'h0);
      step(1, 1,0,32'h48,32'h0, 1,1,0,32'h304,32'h0, 32'hBAD, 0,0,0,0,0,32'h0,32'h0, 0,0,32'h0);

      // After release: ARB with cleared counters, so CPU first, DMA forced on the ninth.
      for (int j = 0; j <= 8; j++) begin
         dcyc = (j == 8);
         mrd  = 32'hE0 + j;
         step(0, 1,0,32'h50,32'h0, 1,0,0,32'h60,32'h0, mrd,
              !dcyc, dcyc, 1,0,0, dcyc ? 32'h60 : 32'h50, 32'h0, (j > 0), 1'b0, mrd);
      end
      step(0, 0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0, 32'hE9, 0,0,0,0,0,32'h0,32'h0, 0,1,32'hE9);

      @(negedge clk);
      #1;
      chk(0, "queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
